// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: small writable program memory, PC and FSM
// issuing one instruction at a time over a valid/ready handshake.
module instr_fetch_unit #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_wdata,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   halted,
    output logic [PC_BITS:0]       retired
);

    localparam int DEPTH = 2 ** PC_BITS;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        HALTED
    } state_t;

    state_t state, state_n;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [INSTR_WIDTH-1:0] mem_q;
    logic                   is_halt;
    logic                   at_end;
    logic                   can_prog;

    assign is_halt  = (mem_q[INSTR_WIDTH-1 -: 2] == 2'b00);
    assign at_end   = (pc == PC_BITS'(DEPTH - 1));
    assign can_prog = (state == IDLE) || (state == HALTED);
    assign busy     = (state == FETCH) || (state == ISSUE)
                   || (state == WAIT);
    assign halted   = (state == HALTED);

    // Memory is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (can_prog && prog_we)
            mem[prog_addr] <= prog_wdata;
        if (state == FETCH)
            mem_q <= mem[pc];
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, HALTED: if (start) state_n = FETCH;
            FETCH:        state_n = ISSUE;
            ISSUE:        state_n = is_halt ? HALTED : WAIT;
            WAIT: begin
                if (instr_ready)
                    state_n = at_end ? HALTED : FETCH;
            end
            default:      state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instruction <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
            retired     <= '0;
        end else begin
            unique case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        pc      <= '0;
                        retired <= '0;
                    end
                end
                ISSUE: begin
                    if (is_halt) begin
                        instruction <= '0;
                    end else begin
                        instruction <= mem_q;
                        instr_valid <= 1'b1;
                    end
                end
                WAIT: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        retired     <= retired + 1'b1;
                        if (!at_end)
                            pc <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
